avalon_addr_sequencer: RTL
==========================

Name: avalon_addr_sequencer

Overview:
- Parametrised successor to the single-register read-address PIO. Nios II programs base address, length, channel and mode over an Avalon-MM slave.
- The block then autonomously steps a read address through sample memory. Each address is handed to the downstream reader with a valid/step handshake.
- Supports single-pass and continuous (ring) modes, a channel tag, sticky status and an interrupt.
- Idle behaviour is backward compatible: out_port follows the BASE register.

Parameters:
- ADDR_W, 12, width of the generated address (out_port).
- CNT_W, 12, width of the length register and index counter.
- CH_W, 2, width of the channel tag (up to 2^CH_W channels).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  3  Avalon register select
- chipselect  in  1  Avalon chip select
- write_n  in  1  Avalon write strobe, active low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, zero wait states, combinational from address
- out_port  out  ADDR_W  current read address
- out_channel  out  CH_W  channel tag latched at START
- out_valid  out  1  out_port holds an address to be consumed
- step  in  1  consumer accepts the address; transfer occurs when out_valid && step
- irq  out  1  level interrupt, equal to done && IRQ_EN

Behaviour:
- One clock, clk. Reset is synchronous and active-high; all state updates on posedge clk.
- Register map (wr = chipselect && !write_n). Unused bits read 0; unmapped addresses 5-7 read 0.
  - 0 BASE [ADDR_W-1:0]: read/write.
  - 1 LEN [CNT_W-1:0]: read/write.
  - 2 CTRL: bit0 START (write-1 pulse, reads 0), bit1 STOP (pulse, reads 0), bit2 CONT, bit3 IRQ_EN, [8+CH_W-1:8] CHAN.
  - 3 STATUS: bit0 busy (read-only), bit1 done (W1C), bit2 err (W1C), [16+CNT_W-1:16] idx (read-only).
  - 4 CUR: out_port readback.
- Reset values:
  - BASE, LEN and CTRL are 0.
  - FSM is IDLE; idx is 0; done and err are 0.
  - out_port=0, out_channel=0, out_valid=0, irq=0.
- FSM states: IDLE and RUN.
  - IDLE:
    - out_valid=0.
    - out_port = BASE register, so a BASE write is visible the next cycle (legacy PIO behaviour).
  - IDLE -> RUN on START with LEN != 0:
    - Latch act_base=BASE, act_len=LEN, act_cont=CONT, out_channel=CHAN.
    - idx=0, out_port=BASE.
    - Next cycle: out_valid=1, busy=1.
  - START with LEN == 0: stay IDLE, set err.
  - RUN, transfer with idx != act_len-1:
    - idx += 1.
    - out_port += 1, modulo 2^ADDR_W (wraps 0xFFF -> 0x000 at the default width).
  - RUN, transfer with idx == act_len-1:
    - If act_cont: idx=0, out_port=act_base, stay in RUN.
    - Otherwise: go to IDLE and set done.
  - RUN, no step: out_port and idx hold; out_valid stays 1.
  - STOP in RUN: go to IDLE next cycle. done is not set by STOP alone.
  - STOP in IDLE: no effect.
- Writes to BASE, LEN or CHAN while in RUN update the registers only. The active run uses the copies latched at START.
- START while busy is ignored; no err.
- Simultaneous events:
  - Transfer in the same cycle as a STOP write: the transfer completes (idx and out_port advance), then IDLE.
  - If that transfer is the final one of a single pass, done is set.
  - START and STOP in the same write: STOP wins, no run starts.
  - Hardware set of done or err in the same cycle as a W1C write: set wins.
- Latency:
  - START write to first out_valid: 1 cycle.
  - Transfer to next address on out_port: 1 cycle.
  - Throughput: 1 address/cycle with step held high.
- Reset mid-RUN: immediate return to reset values next edge; no done, no irq.

Decomposition:
- Shared package holds:
  - register offsets (REG_BASE=0, REG_LEN=1, REG_CTRL=2, REG_STATUS=3, REG_CUR=4);
  - CTRL and STATUS bit positions;
  - FSM state encoding.
- One natural sub-module, addr_seq_core: FSM, idx counter and out_port generator with the valid/step handshake. The top level keeps the Avalon register file and read mux.

Test Plan:
- Reset, then write BASE=0x100 in IDLE -> out_port=0x100 one cycle later, out_valid=0, readdata at addr 0 = 0x100.
- LEN=4, CTRL=START|IRQ_EN, step held 1 -> out_port 0x100, 0x101, 0x102, 0x103 on consecutive cycles. Then IDLE, done=1, irq=1. Writing STATUS=0x2 clears irq.
- BASE=0xFFE, LEN=3, CONT, step toggled 1/0 -> sequence 0xFFE, 0xFFF, 0x000, 0xFFE, ... Address holds while step=0.
- LEN=0 with START -> err=1, busy=0, out_valid never asserts.
- Mid-run: write BASE=0x200 (active run unaffected); then STOP coinciding with step -> one final advance, then IDLE. done=0, out_port=0x200.
- Synchronous reset asserted during RUN with idx=2 -> next cycle out_valid=0, out_port=0, idx=0, irq=0.

Source files
------------

// File: rtl/avalon_addr_sequencer_pkg.sv
// Shared definitions for the Avalon address sequencer: register offsets,
// CTRL/STATUS bit positions and the sequencer state encoding.
package avalon_addr_sequencer_pkg;

   localparam logic [2:0] REG_BASE   = 3'd0;
   localparam logic [2:0] REG_LEN    = 3'd1;
   localparam logic [2:0] REG_CTRL   = 3'd2;
   localparam logic [2:0] REG_STATUS = 3'd3;
   localparam logic [2:0] REG_CUR    = 3'd4;

   localparam int CTRL_START    = 0;
   localparam int CTRL_STOP     = 1;
   localparam int CTRL_CONT     = 2;
   localparam int CTRL_IRQ_EN   = 3;
   localparam int CTRL_CHAN_LSB = 8;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_ERR     = 2;
   localparam int STAT_IDX_LSB = 16;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } seqState_t;

endpackage

// File: rtl/avalon_addr_sequencer_core.sv
// Sequencing engine: IDLE/RUN state machine, index counter and address
// generator with the valid/step handshake toward the sample reader.
module addr_seq_core
   import avalon_addr_sequencer_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 12,
   parameter int CH_W   = 2
)(
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [CNT_W-1:0]  len_i,
   input  logic              cont_i,
   input  logic [CH_W-1:0]   chan_i,
   input  logic              step_i,
   output logic [ADDR_W-1:0] outPort_o,
   output logic [CH_W-1:0]   outChannel_o,
   output logic              outValid_o,
   output logic              busy_o,
   output logic [CNT_W-1:0]  idx_o,
   output logic              doneSet_o,
   output logic              errSet_o
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   seqState_t         state_q, state_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] actBase_q, actBase_d;
   logic [CNT_W-1:0]  actLen_q, actLen_d;
   logic              actCont_q, actCont_d;
   logic [CH_W-1:0]   chan_q, chan_d;
   logic              transfer, lastXfer, launch;

   // STOP in the same write as START suppresses the launch.
   assign launch   = (state_q == ST_IDLE) && start_i && !stop_i && (len_i != '0);
   assign transfer = (state_q == ST_RUN) && step_i;
   assign lastXfer = (idx_q == (actLen_q - CNT_ONE));

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         addr_q    <= '0;
         actBase_q <= '0;
         actLen_q  <= '0;
         actCont_q <= 1'b0;
         chan_q    <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         addr_q    <= addr_d;
         actBase_q <= actBase_d;
         actLen_q  <= actLen_d;
         actCont_q <= actCont_d;
         chan_q    <= chan_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (launch) state_d = ST_RUN;
         ST_RUN:  if (stop_i || (transfer && lastXfer && !actCont_q)) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // A transfer coinciding with STOP still advances before the return to IDLE.
   always_comb begin
      idx_d     = idx_q;
      addr_d    = addr_q;
      actBase_d = actBase_q;
      actLen_d  = actLen_q;
      actCont_d = actCont_q;
      chan_d    = chan_q;
      if (launch) begin
         actBase_d = base_i;
         actLen_d  = len_i;
         actCont_d = cont_i;
         chan_d    = chan_i;
         idx_d     = '0;
         addr_d    = base_i;
      end else if (transfer) begin
         if (!lastXfer) begin
            idx_d  = idx_q + CNT_ONE;
            addr_d = addr_q + ADDR_ONE;
         end else if (actCont_q) begin
            idx_d  = '0;
            addr_d = actBase_q;
         end
      end
   end

   always_comb begin
      outValid_o   = (state_q == ST_RUN);
      busy_o       = (state_q == ST_RUN);
      outPort_o    = (state_q == ST_IDLE) ? base_i : addr_q;
      outChannel_o = chan_q;
      idx_o        = idx_q;
      doneSet_o    = transfer && lastXfer && !actCont_q;
      errSet_o     = (state_q == ST_IDLE) && start_i && !stop_i && (len_i == '0);
   end

endmodule

// File: rtl/avalon_addr_sequencer.sv
// Avalon-MM register file and read mux around the address sequencing core;
// while idle, out_port mirrors BASE like the original read-address PIO.
module avalon_addr_sequencer
   import avalon_addr_sequencer_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 12,
   parameter int CH_W   = 2
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [ADDR_W-1:0] out_port,
   output logic [CH_W-1:0]   out_channel,
   output logic              out_valid,
   input  logic              step,
   output logic              irq
);

   logic              wrEn, ctrlWr, statusWr;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic              cont_q, cont_d;
   logic              irqEn_q, irqEn_d;
   logic [CH_W-1:0]   chan_q, chan_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              busy, doneSet, errSet;
   logic [CNT_W-1:0]  idx;
   logic              unusedWriteBits;

   assign wrEn     = chipselect && !write_n;
   assign ctrlWr   = wrEn && (address == REG_CTRL);
   assign statusWr = wrEn && (address == REG_STATUS);
   assign irq      = done_q && irqEn_q;
   assign unusedWriteBits = ^writedata;

   // START only arrives with a CTRL write, so the core latches the mode and
   // channel fields straight from that same write.
   addr_seq_core #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W),
      .CH_W   (CH_W)
   ) u_core (
      .clk_i        (clk),
      .reset_i      (reset),
      .start_i      (ctrlWr && writedata[CTRL_START]),
      .stop_i       (ctrlWr && writedata[CTRL_STOP]),
      .base_i       (base_q),
      .len_i        (len_q),
      .cont_i       (writedata[CTRL_CONT]),
      .chan_i       (writedata[CTRL_CHAN_LSB +: CH_W]),
      .step_i       (step),
      .outPort_o    (out_port),
      .outChannel_o (out_channel),
      .outValid_o   (out_valid),
      .busy_o       (busy),
      .idx_o        (idx),
      .doneSet_o    (doneSet),
      .errSet_o     (errSet)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         base_q  <= '0;
         len_q   <= '0;
         cont_q  <= 1'b0;
         irqEn_q <= 1'b0;
         chan_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         base_q  <= base_d;
         len_q   <= len_d;
         cont_q  <= cont_d;
         irqEn_q <= irqEn_d;
         chan_q  <= chan_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Sticky flags: a hardware set in the same cycle as a W1C write wins.
   always_comb begin
      base_d  = base_q;
      len_d   = len_q;
      cont_d  = cont_q;
      irqEn_d = irqEn_q;
      chan_d  = chan_q;
      done_d  = done_q;
      err_d   = err_q;
      if (wrEn && (address == REG_BASE)) base_d = writedata[ADDR_W-1:0];
      if (wrEn && (address == REG_LEN))  len_d  = writedata[CNT_W-1:0];
      if (ctrlWr) begin
         cont_d  = writedata[CTRL_CONT];
         irqEn_d = writedata[CTRL_IRQ_EN];
         chan_d  = writedata[CTRL_CHAN_LSB +: CH_W];
      end
      if (statusWr && writedata[STAT_DONE]) done_d = 1'b0;
      if (statusWr && writedata[STAT_ERR])  err_d  = 1'b0;
      if (doneSet) done_d = 1'b1;
      if (errSet)  err_d  = 1'b1;
   end

   always_comb begin
      readdata = '0;
      case (address)
         REG_BASE:   readdata[ADDR_W-1:0] = base_q;
         REG_LEN:    readdata[CNT_W-1:0]  = len_q;
         REG_CTRL: begin
            readdata[CTRL_CONT]                 = cont_q;
            readdata[CTRL_IRQ_EN]               = irqEn_q;
            readdata[CTRL_CHAN_LSB +: CH_W]     = chan_q;
         end
         REG_STATUS: begin
            readdata[STAT_BUSY]                 = busy;
            readdata[STAT_DONE]                 = done_q;
            readdata[STAT_ERR]                  = err_q;
            readdata[STAT_IDX_LSB +: CNT_W]     = idx;
         end
         REG_CUR:    readdata[ADDR_W-1:0] = out_port;
         default:    readdata = '0;
      endcase
   end

endmodule
